writeback_arbiter: RTL and testbench

Round-robin arbiter sharing one commit/writeback port among `NUM_REQ` execute units. Sits between the execute-unit outputs and the commit stage. It replaces fixed-priority merging, so no execute unit can be starved. Grants one requester per cycle into a single registered output slot that drives regfile write, ready-table write, ROB completion and wakeup broadcast.

---
 rtl/writeback_arbiter_if.sv | 42 ++++
 rtl/writeback_arbiter.sv | 75 +++++++
 tb/tb_writeback_arbiter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/writeback_arbiter_if.sv
// Writeback arbiter bus: execute-unit request side plus the single commit slot.
//   req_valid/req_allowin     per-requester handshake
//   req_rob_id/rd_phy/rd_data packed per-requester payload (requester i at [i*W +: W])
//   wb_*                      registered output slot toward the commit stage
//   wake_*                    wakeup broadcast taken from the retiring slot
// modport master: the arbiter; modport slave: the surrounding pipeline.
interface writeback_arbiter_if #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ROB_ID_W = 6,
    parameter int unsigned PHY_W    = 6,
    parameter int unsigned DATA_W   = 32
);
    localparam int unsigned SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0]          req_allowin;
    logic [NUM_REQ*ROB_ID_W-1:0] req_rob_id;
    logic [NUM_REQ*PHY_W-1:0]    req_rd_phy;
    logic [NUM_REQ*DATA_W-1:0]   req_rd_data;

    logic                        wb_valid;
    logic                        wb_allowin;
    logic [ROB_ID_W-1:0]         wb_rob_id;
    logic [PHY_W-1:0]            wb_rd_phy;
    logic [DATA_W-1:0]           wb_rd_data;
    logic [SRC_W-1:0]            wb_src;

    logic                        wake_valid;
    logic [PHY_W-1:0]            wake_rd_phy;

    modport master (
        input  req_valid, req_rob_id, req_rd_phy, req_rd_data, wb_allowin,
        output req_allowin, wb_valid, wb_rob_id, wb_rd_phy, wb_rd_data, wb_src,
               wake_valid, wake_rd_phy
    );

    modport slave (
        output req_valid, req_rob_id, req_rd_phy, req_rd_data, wb_allowin,
        input  req_allowin, wb_valid, wb_rob_id, wb_rd_phy, wb_rd_data, wb_src,
               wake_valid, wake_rd_phy
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Round-robin arbiter sharing one registered commit/writeback slot among
// NUM_REQ execute units.
//   clk, rst   clock; synchronous active-high reset
//   flush      discards the slot and blocks grants this cycle
//   bus        writeback_arbiter_if.master (request handshake, payloads, slot, wakeup)
// req_allowin and wake_valid are combinational; every other output is registered.
module writeback_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ROB_ID_W = 6,
    parameter int unsigned PHY_W    = 6,
    parameter int unsigned DATA_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    writeback_arbiter_if.master  bus
);
    localparam int unsigned SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [SRC_W-1:0]   last;
    logic               slot_free_c;
    logic               found_c;
    logic [SRC_W-1:0]   cand_c;
    logic [SRC_W-1:0]   win_c;
    logic [NUM_REQ-1:0] grant_c;

    assign slot_free_c = ~bus.wb_valid | bus.wb_allowin;

    // Round-robin search starting just after the last winner; only req_valid,
    // last, slot_free and flush feed the grant.
    always_comb begin
        found_c = 1'b0;
        cand_c  = '0;
        win_c   = '0;
        grant_c = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand_c = SRC_W'((32'(last) + k) % NUM_REQ);
            if (!found_c && bus.req_valid[cand_c]) begin
                found_c = 1'b1;
                win_c   = cand_c;
            end
        end
        if (found_c && slot_free_c && !flush) begin
            grant_c[win_c] = 1'b1;
        end
    end

    assign bus.req_allowin = grant_c;

    // Wakeup fires as the slot retires, including during a flush.
    assign bus.wake_valid  = bus.wb_valid & bus.wb_allowin;
    assign bus.wake_rd_phy = bus.wb_rd_phy;

    // Output slot and round-robin pointer; a grant overwrites a retiring slot
    // in the same edge so there is no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            last           <= SRC_W'(NUM_REQ - 1);
            bus.wb_valid   <= 1'b0;
            bus.wb_rob_id  <= '0;
            bus.wb_rd_phy  <= '0;
            bus.wb_rd_data <= '0;
            bus.wb_src     <= '0;
        end else if (|grant_c) begin
            last           <= win_c;
            bus.wb_valid   <= 1'b1;
            bus.wb_rob_id  <= bus.req_rob_id[32'(win_c)*ROB_ID_W +: ROB_ID_W];
            bus.wb_rd_phy  <= bus.req_rd_phy[32'(win_c)*PHY_W +: PHY_W];
            bus.wb_rd_data <= bus.req_rd_data[32'(win_c)*DATA_W +: DATA_W];
            bus.wb_src     <= win_c;
        end else if (bus.wb_allowin || flush) begin
            bus.wb_valid   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;
    localparam int unsigned N  = 4;
    localparam int unsigned RW = 6;
    localparam int unsigned PW = 6;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    always #5 clk = ~clk;

    writeback_arbiter_if #(.NUM_REQ(N), .ROB_ID_W(RW), .PHY_W(PW), .DATA_W(DW)) bus ();

    writeback_arbiter #(.NUM_REQ(N), .ROB_ID_W(RW), .PHY_W(PW), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: slot contents and the index of the last winner.
    logic          m_valid;
    logic [RW-1:0] m_rob;
    logic [PW-1:0] m_phy;
    logic [DW-1:0] m_data;
    int            m_src;
    int            m_last;

    logic [RW-1:0] p_rob  [N];
    logic [PW-1:0] p_phy  [N];
    logic [DW-1:0] p_data [N];

    logic [N-1:0]  obs_grant;
    logic          obs_valid;
    logic          obs_wake;
    logic [RW-1:0] obs_rob;
    logic [PW-1:0] obs_wake_phy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_rob   = '0;
        m_phy   = '0;
        m_data  = '0;
        m_src   = 0;
        m_last  = N - 1;
    endtask

    // One clock: drive at negedge, check every output against the model, then
    // advance the model across the posedge.
    task automatic step(input logic [N-1:0] v, input logic a, input logic f);
        int           win;
        logic         slot_free;
        logic [N-1:0] exp_grant;
        @(negedge clk);
        bus.req_valid  = v;
        bus.wb_allowin = a;
        flush          = f;
        for (int i = 0; i < N; i++) begin
            bus.req_rob_id[i*RW +: RW]  = p_rob[i];
            bus.req_rd_phy[i*PW +: PW]  = p_phy[i];
            bus.req_rd_data[i*DW +: DW] = p_data[i];
        end
        #1;
        slot_free = !m_valid || a;
        win = -1;
        for (int k = 1; k <= N; k++) begin
            if (win < 0 && v[(m_last + k) % N]) win = (m_last + k) % N;
        end
        exp_grant = (win >= 0 && slot_free && !f) ? N'(1 << win) : '0;
        chk("req_allowin", 64'(bus.req_allowin), 64'(exp_grant));
        chk("wb_valid",    64'(bus.wb_valid),    64'(m_valid));
        chk("wb_rob_id",   64'(bus.wb_rob_id),   64'(m_rob));
        chk("wb_rd_phy",   64'(bus.wb_rd_phy),   64'(m_phy));
        chk("wb_rd_data",  64'(bus.wb_rd_data),  64'(m_data));
        chk("wb_src",      64'(bus.wb_src),      64'(m_src));
        chk("wake_valid",  64'(bus.wake_valid),  64'(m_valid && a));
        chk("wake_rd_phy", 64'(bus.wake_rd_phy), 64'(m_phy));
        obs_grant    = bus.req_allowin;
        obs_valid    = bus.wb_valid;
        obs_wake     = bus.wake_valid;
        obs_rob      = bus.wb_rob_id;
        obs_wake_phy = bus.wake_rd_phy;
        @(posedge clk);
        if (exp_grant != '0) begin
            m_valid = 1'b1;
            m_rob   = p_rob[win];
            m_phy   = p_phy[win];
            m_data  = p_data[win];
            m_src   = win;
            m_last  = win;
        end else if (a || f) begin
            m_valid = 1'b0;
        end
    endtask

    initial begin
        logic [N-1:0] order [5];
        logic [N-1:0] alt   [4];
        order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        alt   = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};

        rst = 1'b1;
        flush = 1'b0;
        bus.req_valid = '0;
        bus.wb_allowin = 1'b0;
        bus.req_rob_id = '0;
        bus.req_rd_phy = '0;
        bus.req_rd_data = '0;
        for (int i = 0; i < N; i++) begin
            p_rob[i]  = RW'(10 + i);
            p_phy[i]  = PW'(20 + i);
            p_data[i] = 32'hA0 + 32'(i);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Reset state: idle outputs, no grant without requests.
        step('0, 1'b1, 1'b0);
        chk("reset_grant", 64'(obs_grant), 64'h0);
        chk("reset_valid", 64'(obs_valid), 64'h0);

        // First grants walk 0,1,2,3,0.
        for (int s = 0; s < 5; s++) begin
            step(4'b1111, 1'b1, 1'b0);
            chk("rr_order", 64'(obs_grant), 64'(order[s]));
        end

        // Sparse requesters alternate 1,3.
        for (int s = 0; s < 4; s++) begin
            step(4'b1010, 1'b1, 1'b0);
            chk("sparse_order", 64'(obs_grant), 64'(alt[s]));
        end

        // Backpressure: slot holds rob 5 while commit stalls.
        p_rob[0] = RW'(5);
        step(4'b0001, 1'b1, 1'b0);
        chk("bp_load_grant", 64'(obs_grant), 64'h1);
        p_rob[0] = RW'(9);
        for (int s = 0; s < 3; s++) begin
            step(4'b0001, 1'b0, 1'b0);
            chk("bp_no_grant", 64'(obs_grant), 64'h0);
            chk("bp_hold_rob", 64'(obs_rob), 64'd5);
        end
        step(4'b0001, 1'b1, 1'b0);
        chk("bp_release_grant", 64'(obs_grant), 64'h1);
        step(4'b0000, 1'b0, 1'b0);
        chk("bp_no_bubble", 64'(obs_valid), 64'h1);
        chk("bp_new_rob", 64'(obs_rob), 64'd9);

        // Flush: no grant in the flush cycle, slot empty after, 2 then wins.
        step(4'b0100, 1'b0, 1'b1);
        chk("flush_no_grant", 64'(obs_grant), 64'h0);
        step(4'b0100, 1'b0, 1'b0);
        chk("flush_cleared", 64'(obs_valid), 64'h0);
        chk("flush_then_2", 64'(obs_grant), 64'b0100);

        // Wrap-around from last=3.
        step(4'b1000, 1'b1, 1'b0);
        chk("wrap_set3", 64'(obs_grant), 64'b1000);
        step(4'b1001, 1'b1, 1'b0);
        chk("wrap_to0", 64'(obs_grant), 64'b0001);
        step(4'b1001, 1'b1, 1'b0);
        chk("wrap_to3", 64'(obs_grant), 64'b1000);

        // Wakeup mirrors the retiring slot.
        p_phy[0] = PW'(17);
        step(4'b0001, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        chk("wake_stalled", 64'(obs_wake), 64'h0);
        step(4'b0000, 1'b1, 1'b0);
        chk("wake_fire", 64'(obs_wake), 64'h1);
        chk("wake_phy", 64'(obs_wake_phy), 64'd17);

        // Randomized traffic against the model.
        for (int s = 0; s < 600; s++) begin
            for (int i = 0; i < N; i++) begin
                p_rob[i]  = RW'($urandom);
                p_phy[i]  = PW'($urandom);
                p_data[i] = $urandom;
            end
            step(N'($urandom), ($urandom_range(3, 0) != 0), ($urandom_range(9, 0) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
